multicycle_datapath: RTL



---
 rtl/multicycle_datapath.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle integer core (FETCH/DECODE/EXEC/MEM/WB) with handshaked instruction and data memories.
module multicycle_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS = 8,
    parameter int PC_WIDTH = 16,
    parameter int DMEM_AW = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int RET_REG = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DMEM_AW-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  retire,
    output logic [PC_WIDTH-1:0]   retire_pc,
    output logic [2:0]            cc_out,
    output logic                  illegal_op
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_AND = 5'd1, OP_MOV = 5'd2, OP_LD = 5'd3, OP_ST = 5'd4,
                           OP_BR = 5'd5, OP_JMP = 5'd6, OP_JSR = 5'd7, OP_JSRR = 5'd8;
    localparam logic [2:0] FORMAT_IR = 3'd0, FORMAT_II = 3'd1;
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t state, state_nxt;

    logic [31:0] ir;
    logic [PC_WIDTH-1:0] pc, npc, pc4, br_tgt, reg_tgt, ex_npc;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] a, b, d, res, imm_x, opnd, ex_res;
    logic [IW-1:0] dst_i, s1_i, s2_i, widx, ex_widx;
    logic [4:0] op;
    logic [2:0] fmt, cc;
    logic [15:0] imm;
    logic wen, cen, bad, ill, ex_wen, ex_cen, ex_bad, is_mem;
    logic unused;

    assign op = ir[31:27];
    assign fmt = ir[26:24];
    assign imm = ir[15:0];
    assign dst_i = ir[20 +: IW];
    assign s1_i = ir[16 +: IW];
    assign s2_i = ir[8 +: IW];
    assign unused = ^ir;

    assign imm_x = DATA_WIDTH'($signed(imm));
    assign opnd = (fmt == FORMAT_II) ? imm_x : b;
    assign pc4 = pc + PC_WIDTH'(4);
    assign br_tgt = pc4 + PC_WIDTH'($signed({imm, 2'b00}));
    assign reg_tgt = PC_WIDTH'(a) & ~PC_WIDTH'(3);
    assign is_mem = (op == OP_LD) || (op == OP_ST);

    assign imem_addr = pc;
    assign dmem_we = (op == OP_ST);
    assign dmem_addr = DMEM_AW'(a + imm_x);
    assign dmem_wdata = d;
    assign retire = (state == WB);
    assign retire_pc = pc;
    assign cc_out = cc;
    assign illegal_op = ill;

    function automatic logic [2:0] cc_of(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? 3'b100 : (v == '0) ? 3'b010 : 3'b001;
    endfunction

    // Result, destination and next PC, computed in EXEC from operands latched in DECODE
    always_comb begin
        ex_res = '0;
        ex_npc = pc4;
        ex_wen = 1'b0;
        ex_cen = 1'b0;
        ex_widx = dst_i;
        ex_bad = 1'b0;
        case (op)
            OP_ADD: begin ex_res = a + opnd; ex_wen = 1'b1; ex_cen = 1'b1; end
            OP_AND: begin ex_res = a & opnd; ex_wen = 1'b1; ex_cen = 1'b1; end
            OP_MOV: begin ex_res = opnd; ex_widx = s1_i; ex_wen = 1'b1; ex_cen = 1'b1; end
            OP_LD: begin ex_wen = 1'b1; ex_cen = 1'b1; end
            OP_ST: ;
            OP_BR: ex_npc = |(fmt & cc) ? br_tgt : pc4;
            OP_JMP: ex_npc = reg_tgt;
            OP_JSR: begin ex_res = DATA_WIDTH'(pc4); ex_widx = IW'(RET_REG); ex_wen = 1'b1; ex_npc = br_tgt; end
            OP_JSRR: begin ex_res = DATA_WIDTH'(pc4); ex_widx = IW'(RET_REG); ex_wen = 1'b1; ex_npc = reg_tgt; end
            default: ex_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state)
            FETCH: begin
                imem_req = lock;
                state_nxt = (lock && imem_ready) ? DECODE : FETCH;
            end
            DECODE: state_nxt = EXEC;
            EXEC: state_nxt = is_mem ? MEM : WB;
            MEM: begin
                dmem_req = 1'b1;
                state_nxt = dmem_ready ? WB : MEM;
            end
            WB: state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            cc <= 3'b010;
            ill <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (imem_req && imem_ready) ir <= imem_rdata;
            if (state == DECODE) begin
                a <= regs[s1_i];
                b <= regs[s2_i];
                d <= regs[dst_i];
            end
            if (state == EXEC) begin
                res <= ex_res;
                npc <= ex_npc;
                wen <= ex_wen;
                cen <= ex_cen;
                widx <= ex_widx;
                bad <= ex_bad;
            end
            if (dmem_req && dmem_ready && !dmem_we) res <= dmem_rdata;
            if (state == WB) begin
                pc <= npc;
                if (wen) regs[widx] <= res;
                if (cen) cc <= cc_of(res);
                if (bad) ill <= 1'b1;
            end
        end
    end
endmodule
